// File: rtl/ram_lsu_ctrl.sv
// RV32I load/store sequencer for a word-addressed RAM with 1-cycle registered read and byte lanes.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two word accesses instead of erroring.
module ram_lsu_ctrl #(
    parameter int unsigned MEM_WORDS = 295
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [29:0] ram_r_addr,
    input  logic [31:0] ram_r_val,
    output logic        ram_w_enable,
    output logic [29:0] ram_w_addr,
    output logic [31:0] ram_w_val,
    output logic [3:0]  ram_byte_en
);

    // state  | meaning
    // IDLE   | req_ready high, waiting for a request
    // ISSUE0 | first word access on the RAM (nothing driven for errors)
    // ISSUE1 | second word of a split access
    // WAIT   | read data on ram_r_val, format the load result
    // RESP   | resp_valid pulse
    typedef enum logic [2:0] {S_IDLE, S_ISSUE0, S_ISSUE1, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic        w_en_q;
    logic [3:0]  be_q;
    logic        q_we;
    logic [2:0]  q_funct3;
    logic [1:0]  q_off;
    logic        q_err;

    logic [1:0]  off;
    logic [29:0] w0;
    logic [3:0]  base_mask;
    logic [3:0]  be_lo;
    logic        legal;
    logic        misal;
    logic        err;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [29:0] w1;
    logic [7:0]  be_wide;
    logic        q_split;
    logic [29:0] q_w1;
    logic [3:0]  q_be_hi;
    logic [31:0] q_whi;
    logic [31:0] lo_word;
`endif

    function automatic logic [31:0] load_fmt(input logic [63:0] d, input logic [1:0] sh,
                                             input logic [2:0] f3);
        logic [31:0] s;
        s = 32'(d >> {sh, 3'b000});
        case (f3[1:0])
            2'd0:    load_fmt = {{24{s[7] & ~f3[2]}}, s[7:0]};
            2'd1:    load_fmt = {{16{s[15] & ~f3[2]}}, s[15:0]};
            default: load_fmt = s;
        endcase
    endfunction

    always_comb begin
        off = req_addr[1:0];
        w0  = req_addr[31:2];
        case (req_funct3[1:0])
            2'd0:    base_mask = 4'h1;
            2'd1:    base_mask = 4'h3;
            default: base_mask = 4'hF;
        endcase
        if (req_we)
            legal = (req_funct3 <= 3'd2);
        else
            legal = (req_funct3 != 3'd3) && (req_funct3 != 3'd6) && (req_funct3 != 3'd7);
        misal = ((req_funct3[1:0] == 2'd1) && (off == 2'd3)) ||
                ((req_funct3[1:0] == 2'd2) && (off != 2'd0));
`ifdef LSU_MISALIGN_SPLIT_EN
        w1      = w0 + 30'd1;
        be_wide = {4'b0000, base_mask} << off;
        be_lo   = be_wide[3:0];
        err     = !legal || (w0 >= 30'(MEM_WORDS)) || (misal && (w1 >= 30'(MEM_WORDS)));
`else
        be_lo   = base_mask << off;
        err     = !legal || (w0 >= 30'(MEM_WORDS)) || misal;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            ram_r_addr <= '0;
            ram_w_addr <= '0;
            ram_w_val  <= '0;
            w_en_q     <= 1'b0;
            be_q       <= '0;
            q_we       <= 1'b0;
            q_funct3   <= '0;
            q_off      <= '0;
            q_err      <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            q_split    <= 1'b0;
            q_w1       <= '0;
            q_be_hi    <= '0;
            q_whi      <= '0;
            lo_word    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        q_we      <= req_we;
                        q_funct3  <= req_funct3;
                        q_off     <= off;
                        q_err     <= err;
`ifdef LSU_MISALIGN_SPLIT_EN
                        q_split   <= misal;
                        q_w1      <= w1;
                        q_be_hi   <= be_wide[7:4];
                        q_whi     <= req_wdata >> (6'd32 - {1'b0, off, 3'b000});
`endif
                        state     <= S_ISSUE0;
                        if (!err) begin
                            if (req_we) begin
                                w_en_q     <= 1'b1;
                                ram_w_addr <= w0;
                                ram_w_val  <= req_wdata << {off, 3'b000};
                                be_q       <= be_lo;
                            end else begin
                                ram_r_addr <= w0;
                            end
                        end
                    end
                end
                S_ISSUE0: begin
                    if (q_err) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        state      <= S_RESP;
                    end
`ifdef LSU_MISALIGN_SPLIT_EN
                    else if (q_split) begin
                        state <= S_ISSUE1;
                        if (q_we) begin
                            ram_w_addr <= q_w1;
                            ram_w_val  <= q_whi;
                            be_q       <= q_be_hi;
                        end else begin
                            ram_r_addr <= q_w1;
                        end
                    end
`endif
                    else if (q_we) begin
                        w_en_q     <= 1'b0;
                        be_q       <= '0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        state <= S_WAIT;
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                S_ISSUE1: begin
                    if (q_we) begin
                        w_en_q     <= 1'b0;
                        be_q       <= '0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        lo_word <= ram_r_val;
                        state   <= S_WAIT;
                    end
                end
`endif
                S_WAIT: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    resp_rdata <= load_fmt(q_split ? {ram_r_val, lo_word} : {32'd0, ram_r_val},
                                           q_off, q_funct3);
`else
                    resp_rdata <= load_fmt({32'd0, ram_r_val}, q_off, q_funct3);
`endif
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The RAM writes on byte lanes alone, so gate them with reset combinationally.
    assign ram_w_enable = w_en_q & ~rst;
    assign ram_byte_en  = be_q & {4{ram_w_enable}};

endmodule

// File: tb/tb_ram_lsu_ctrl.sv
// Bench for ram_lsu_ctrl: directed cases plus random loads/stores against a byte-level memory model.
module tb_ram_lsu_ctrl;
    localparam int MEM = 295;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [29:0] ram_r_addr;
    logic [31:0] ram_r_val;
    logic        ram_w_enable;
    logic [29:0] ram_w_addr;
    logic [31:0] ram_w_val;
    logic [3:0]  ram_byte_en;

    always #5 clk = ~clk;

    ram_lsu_ctrl #(.MEM_WORDS(MEM)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_r_addr(ram_r_addr), .ram_r_val(ram_r_val),
        .ram_w_enable(ram_w_enable), .ram_w_addr(ram_w_addr),
        .ram_w_val(ram_w_val), .ram_byte_en(ram_byte_en)
    );

    logic [31:0] mem     [MEM];
    logic [31:0] ref_mem [MEM];
    logic        sync_req = 1'b1;
    int          wr_count = 0;
    int          resp_count = 0;
    int          be_viol = 0;
    int          n_total = 0;
    int          n_bad = 0;

    // RAM: registered read, byte-lane write; preloaded from the reference image on request
    always @(posedge clk) begin
        ram_r_val <= (ram_r_addr < 30'(MEM)) ? mem[int'(ram_r_addr)] : 32'hDEAD_BEEF;
        if (sync_req)
            for (int i = 0; i < MEM; i++) mem[i] <= ref_mem[i];
        if (ram_byte_en != 4'b0000) begin
            wr_count <= wr_count + 1;
            if (ram_w_addr < 30'(MEM))
                for (int i = 0; i < 4; i++)
                    if (ram_byte_en[i]) mem[int'(ram_w_addr)][8*i +: 8] <= ram_w_val[8*i +: 8];
        end
        if (resp_valid) resp_count <= resp_count + 1;
    end

    always @(negedge clk)
        if (!ram_w_enable && ram_byte_en != 4'b0000) be_viol <= be_viol + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        return ref_mem[int'(a[31:2])][8*a[1:0] +: 8];
    endfunction

    task automatic put_byte(input logic [31:0] a, input logic [7:0] b);
        ref_mem[int'(a[31:2])][8*a[1:0] +: 8] = b;
    endtask

    logic [29:0] wa [1:4];
    logic [31:0] wv [1:4];
    logic [3:0]  wb [1:4];
    logic [31:0] got_rdata;

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        int n, lat, wr0, r0, exp_lat, exp_wr;
        logic legal, misal, split, err;
        logic [29:0] w0, w1;
        logic [31:0] exp_rd;
        w0 = addr[31:2];
        w1 = w0 + 30'd1;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        misal = (n == 2 && addr[1:0] == 2'd3) || (n == 4 && addr[1:0] != 2'd0);
        split = misal && SPLIT;
        err = !legal || (w0 >= 30'(MEM)) || (split && w1 >= 30'(MEM)) || (misal && !SPLIT);
        exp_rd = '0;
        if (!err && !we) begin
            for (int i = 0; i < n; i++) exp_rd |= 32'(get_byte(addr + 32'(i))) << (8*i);
            if (!f3[2] && n < 4 && exp_rd[8*n-1]) exp_rd |= ~((32'd1 << (8*n)) - 32'd1);
        end
        exp_lat = err ? 2 : (we ? (split ? 3 : 2) : (split ? 4 : 3));
        exp_wr  = (err || !we) ? 0 : (split ? 2 : 1);

        @(negedge clk);
        check_val("ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        wr0 = wr_count; r0 = resp_count;
        lat = 0; got_rdata = 32'hBAD0_BAD0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                if (!err && !we) check_val("r_addr", 32'(ram_r_addr), 32'(w0));
            end
            if (k <= 4) begin wa[k] = ram_w_addr; wv[k] = ram_w_val; wb[k] = ram_byte_en; end
            if (resp_valid) begin
                lat = k;
                got_rdata = resp_rdata;
                check_val("err", 32'(resp_err), 32'(err));
            end
        end
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("rdata", got_rdata, exp_rd);
        check_val("writes", 32'(wr_count - wr0), 32'(exp_wr));
        @(negedge clk);
        check_val("resp_pulse", 32'(resp_valid), 32'd0);
        check_val("resp_count", 32'(resp_count - r0), 32'd1);
        if (!err && we) begin
            for (int i = 0; i < n; i++) put_byte(addr + 32'(i), wd[8*i +: 8]);
            check_val("mem_w0", mem[int'(w0)], ref_mem[int'(w0)]);
            if (split) check_val("mem_w1", mem[int'(w1)], ref_mem[int'(w1)]);
        end
    endtask

    initial begin
        int wr0, r0;
        logic [31:0] a;
        for (int i = 0; i < MEM; i++) ref_mem[i] = $urandom;
        ref_mem[2] = 32'h4433_2211;
        ref_mem[3] = 32'h8877_6655;
        ref_mem[4] = 32'h8081_8283;
        repeat (2) @(negedge clk);
        sync_req = 1'b0;
        @(negedge clk);
        check_val("rst_ready", 32'(req_ready), 32'd1);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_wen", 32'(ram_w_enable), 32'd0);
        check_val("rst_be", 32'(ram_byte_en), 32'd0);
        check_val("rst_r_addr", 32'(ram_r_addr), 32'd0);
        check_val("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b0;

        run_req(1'b0, 3'd0, 32'h12, 32'd0);
        check_val("lb_0x12", got_rdata, 32'hFFFF_FF81);
        run_req(1'b0, 3'd4, 32'h12, 32'd0);
        check_val("lbu_0x12", got_rdata, 32'h0000_0081);
        run_req(1'b1, 3'd1, 32'h22, 32'h1234_ABCD);
        check_val("sh_waddr", 32'(wa[1]), 32'd8);
        check_val("sh_wval", wv[1], 32'hABCD_0000);
        check_val("sh_be", 32'(wb[1]), 32'hC);
        check_val("sh_be_after", 32'(wb[2]), 32'h0);
        run_req(1'b0, 3'd2, 32'h49D, 32'd0);
        run_req(1'b1, 3'd3, 32'h10, 32'h5555_5555);
        run_req(1'b0, 3'd2, 32'(294*4+1), 32'd0);
        run_req(1'b0, 3'd2, 32'hFFFF_FFFD, 32'd0);
        run_req(1'b0, 3'd2, 32'h0A, 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
        check_val("split_lw", got_rdata, 32'h6655_4433);
`endif
        run_req(1'b1, 3'd2, 32'h0B, 32'hAABB_CCDD);
`ifdef LSU_MISALIGN_SPLIT_EN
        check_val("split_sw_a0", 32'(wa[1]), 32'd2);
        check_val("split_sw_v0", wv[1], 32'hDD00_0000);
        check_val("split_sw_b0", 32'(wb[1]), 32'h8);
        check_val("split_sw_a1", 32'(wa[2]), 32'd3);
        check_val("split_sw_v1", wv[2], 32'h00AA_BBCC);
        check_val("split_sw_b1", 32'(wb[2]), 32'h7);
`else
        check_val("nosplit_sw_be", 32'(wb[1]), 32'h0);
`endif

        for (int t = 0; t < 250; t++) begin
            a = (32'($urandom_range(0, 300)) << 2) | 32'($urandom_range(0, 3));
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        // reset during the first issue cycle of a store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_wdata = 32'h1357_9BDF;
        req_addr = SPLIT ? 32'h0B : 32'h10;
        wr0 = wr_count; r0 = resp_count;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_val("abort_wen", 32'(ram_w_enable), 32'd0);
        check_val("abort_be", 32'(ram_byte_en), 32'd0);
        @(negedge clk);
        check_val("abort_ready", 32'(req_ready), 32'd1);
        check_val("abort_resp", 32'(resp_valid), 32'd0);
        check_val("abort_waddr", 32'(ram_w_addr), 32'd0);
        check_val("abort_wval", ram_w_val, 32'd0);
        check_val("abort_raddr", 32'(ram_r_addr), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_val("abort_writes", 32'(wr_count - wr0), 32'd0);
        check_val("abort_resps", 32'(resp_count - r0), 32'd0);
        for (int i = 2; i <= 4; i++) check_val("abort_mem", mem[i], ref_mem[i]);
        run_req(1'b0, 3'd2, 32'h10, 32'd0);

        check_val("be_without_wen", 32'(be_viol), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
